// File: rtl/dcp_egress_port.sv
// dcp_egress_port
// Egress end of the decoupled switch fabric, one per crossbar output.
// Accepts crossbar beats, drops (and counts) beats not addressed to PORT_ID,
// buffers good beats as {src, payload} in a DEPTH-entry FIFO and re-presents
// them downstream on a valid/ready interface.
//
// Ports:
//   iClk, iRst          clock, asynchronous active-high reset
//   iDcpVld/oDcpRdy     crossbar handshake; iDcpPld payload, iDcpDst route tag
//                       (source ID carried in iDcpPld[AW +: SW])
//   oVld/iRdy/oPld/oSrc downstream handshake, FIFO-head payload and source
//   oLevel              FIFO occupancy (0..DEPTH)
//   oSrcCnt             packed saturating per-source good-beat counters
//   oErrCnt/oDstErr     saturating misroute counter and sticky misroute flag
module dcp_egress_port #(
  parameter int DW      = 8,
  parameter int AW      = 4,
  parameter int N       = 4,
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4,
  parameter int CW      = 8,
  localparam int SW     = $clog2(N),
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iDcpVld,
  output logic            oDcpRdy,
  input  logic [DW-1:0]   iDcpPld,
  input  logic [AW-1:0]   iDcpDst,
  output logic            oVld,
  input  logic            iRdy,
  output logic [DW-1:0]   oPld,
  output logic [SW-1:0]   oSrc,
  output logic [LW-1:0]   oLevel,
  output logic [N*CW-1:0] oSrcCnt,
  output logic [CW-1:0]   oErrCnt,
  output logic            oDstErr
);

  localparam int PW = $clog2(DEPTH);

  logic [SW+DW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [CW-1:0]    r_cnt [N];
  logic [CW-1:0]    r_err;
  logic             r_dst_err;

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_good;
  logic             w_push;
  logic             w_bad;
  logic             w_pop;
  logic [SW-1:0]    w_src;
  logic [SW+DW-1:0] w_head;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  // Ready comes only from the registered level (and reset), never from iRdy,
  // so a pop on a full FIFO reopens ingress one cycle later.
  assign oDcpRdy  = !iRst && !w_full;
  assign w_accept = iDcpVld && oDcpRdy;
  assign w_good   = (iDcpDst == AW'(PORT_ID));
  assign w_push   = w_accept && w_good;
  assign w_bad    = w_accept && !w_good;
  assign w_pop    = !w_empty && iRdy;
  assign w_src    = iDcpPld[AW +: SW];

  // Head is forced to zero when empty so the outputs are defined without
  // having to reset the storage array.
  assign w_head   = w_empty ? '0 : r_mem[r_rptr];
  assign oVld     = !w_empty;
  assign oPld     = w_head[DW-1:0];
  assign oSrc     = w_head[SW+DW-1:DW];
  assign oLevel   = r_level;
  assign oErrCnt  = r_err;
  assign oDstErr  = r_dst_err;

  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_src, iDcpPld};
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int unsigned s = 0; s < N; s++) begin
        r_cnt[s] <= '0;
      end
      r_err     <= '0;
      r_dst_err <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < N; s++) begin
        if (w_push && (w_src == SW'(s)) && (r_cnt[s] != '1)) begin
          r_cnt[s] <= r_cnt[s] + 1'b1;
        end
      end
      if (w_bad) begin
        r_dst_err <= 1'b1;
        if (r_err != '1) begin
          r_err <= r_err + 1'b1;
        end
      end
    end
  end

  always_comb begin
    oSrcCnt = '0;
    for (int unsigned s = 0; s < N; s++) begin
      oSrcCnt[s*CW +: CW] = r_cnt[s];
    end
  end

endmodule

// File: tb/tb_dcp_egress_port.sv
module tb_dcp_egress_port;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int N     = 4;
  localparam int SW    = 2;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int CW    = 8;
  localparam int CWS   = 4;

  logic            iClk = 1'b0;
  logic            iRst = 1'b1;
  logic            iDcpVld = 1'b0;
  logic [DW-1:0]   iDcpPld = '0;
  logic [AW-1:0]   iDcpDst = '0;
  logic            iRdy = 1'b0;

  logic            oDcpRdy, oVld, oDstErr;
  logic [DW-1:0]   oPld;
  logic [SW-1:0]   oSrc;
  logic [LW-1:0]   oLevel;
  logic [N*CW-1:0] oSrcCnt;
  logic [CW-1:0]   oErrCnt;

  logic             s_oDcpRdy, s_oVld, s_oDstErr;
  logic [DW-1:0]    s_oPld;
  logic [SW-1:0]    s_oSrc;
  logic [LW-1:0]    s_oLevel;
  logic [N*CWS-1:0] s_oSrcCnt;
  logic [CWS-1:0]   s_oErrCnt;

  dcp_egress_port #(.DW(DW), .AW(AW), .N(N), .PORT_ID(0), .DEPTH(DEPTH), .CW(CW)) u_dut (
    .iClk(iClk), .iRst(iRst), .iDcpVld(iDcpVld), .oDcpRdy(oDcpRdy),
    .iDcpPld(iDcpPld), .iDcpDst(iDcpDst), .oVld(oVld), .iRdy(iRdy),
    .oPld(oPld), .oSrc(oSrc), .oLevel(oLevel), .oSrcCnt(oSrcCnt),
    .oErrCnt(oErrCnt), .oDstErr(oDstErr));

  // Narrow-counter instance on the same stimulus to exercise saturation.
  dcp_egress_port #(.DW(DW), .AW(AW), .N(N), .PORT_ID(0), .DEPTH(DEPTH), .CW(CWS)) u_sat (
    .iClk(iClk), .iRst(iRst), .iDcpVld(iDcpVld), .oDcpRdy(s_oDcpRdy),
    .iDcpPld(iDcpPld), .iDcpDst(iDcpDst), .oVld(s_oVld), .iRdy(iRdy),
    .oPld(s_oPld), .oSrc(s_oSrc), .oLevel(s_oLevel), .oSrcCnt(s_oSrcCnt),
    .oErrCnt(s_oErrCnt), .oDstErr(s_oDstErr));

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Behavioural model: a queue of beats plus plain integer counters.
  logic [DW-1:0] mq_pld[$];
  logic [SW-1:0] mq_src[$];
  logic [DW-1:0] log_q[$];
  int  mcnt[N];
  int  merr = 0;
  bit  mflag = 0;
  int  m_sz;
  bit  m_acc, m_pop;

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mq_pld.delete();
      mq_src.delete();
      for (int s = 0; s < N; s++) mcnt[s] = 0;
      merr  = 0;
      mflag = 0;
    end else begin
      m_sz  = mq_pld.size();
      m_acc = iDcpVld && (m_sz < DEPTH);
      m_pop = (m_sz > 0) && iRdy;
      if (m_pop) begin
        log_q.push_back(mq_pld.pop_front());
        void'(mq_src.pop_front());
      end
      if (m_acc) begin
        if (iDcpDst == 0) begin
          mq_pld.push_back(iDcpPld);
          mq_src.push_back(iDcpPld[AW +: SW]);
          mcnt[iDcpPld[AW +: SW]]++;
        end else begin
          merr++;
          mflag = 1;
        end
      end
    end
  end

  logic [N*CW-1:0]  e_cnt;
  logic [N*CWS-1:0] e_cnts;
  int c_sz;

  always @(negedge iClk) begin
    c_sz   = mq_pld.size();
    e_cnt  = '0;
    e_cnts = '0;
    for (int s = 0; s < N; s++) begin
      e_cnt[s*CW +: CW]    = CW'(sat(mcnt[s], CW));
      e_cnts[s*CWS +: CWS] = CWS'(sat(mcnt[s], CWS));
    end
    check("oVld", oVld, c_sz != 0);
    check("oDcpRdy", oDcpRdy, !iRst && (c_sz < DEPTH));
    check("oLevel", oLevel, c_sz);
    if (c_sz != 0) begin
      check("oPld", oPld, mq_pld[0]);
      check("oSrc", oSrc, mq_src[0]);
    end
    check("oSrcCnt", oSrcCnt, e_cnt);
    check("oErrCnt", oErrCnt, sat(merr, CW));
    check("oDstErr", oDstErr, mflag);
    check("sat_oSrcCnt", s_oSrcCnt, e_cnts);
    check("sat_oErrCnt", s_oErrCnt, sat(merr, CWS));
  end

  // Downstream ready driver; applied 2 time units after the falling edge.
  int rdy_mode = 0;
  bit rdy_fixed = 0;
  int rdy_ph = 0;
  initial begin
    forever begin
      @(negedge iClk);
      #2;
      rdy_ph++;
      case (rdy_mode)
        1:       iRdy = rdy_ph[1];
        2:       iRdy = 1'($urandom_range(0, 1));
        default: iRdy = rdy_fixed;
      endcase
    end
  end

  task automatic tick();
    @(negedge iClk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] p, input logic [AW-1:0] d);
    int n;
    bit got;
    n = 0;
    iDcpVld = 1'b1;
    iDcpPld = p;
    iDcpDst = d;
    do begin
      got = oDcpRdy;
      tick();
      n++;
    end while (!got && n < 64);
    check("send_accepted", got, 1);
    iDcpVld = 1'b0;
  endtask

  task automatic drain();
    int n;
    rdy_mode  = 0;
    rdy_fixed = 1;
    n = 0;
    while (mq_pld.size() != 0 && n < 64) begin
      tick();
      n++;
    end
    tick();
    check("drain_done", mq_pld.size(), 0);
  endtask

  task automatic do_reset();
    iRst    = 1'b1;
    iDcpVld = 1'b0;
    tick();
    tick();
    check("rst_oVld", oVld, 0);
    check("rst_oDcpRdy", oDcpRdy, 0);
    check("rst_oLevel", oLevel, 0);
    check("rst_oPld", oPld, 0);
    check("rst_oSrc", oSrc, 0);
    check("rst_oSrcCnt", oSrcCnt, 0);
    check("rst_oErrCnt", oErrCnt, 0);
    check("rst_oDstErr", oDstErr, 0);
    iRst = 1'b0;
    tick();
  endtask

  function automatic logic [DW-1:0] logv(input int i);
    return (log_q.size() > i) ? log_q[i] : 8'hxx;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    do_reset();

    // Four in-order beats, one per source.
    rdy_fixed = 1;
    log_q.delete();
    for (int i = 0; i < 4; i++) send(8'(i * 16), 4'd0);
    tick(); tick(); tick();
    check("t1_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_order", logv(i), 8'(i * 16));
    check("t1_srccnt", oSrcCnt, 32'h01010101);
    check("t1_errcnt", oErrCnt, 0);

    // Fill to DEPTH with downstream stalled; fifth beat held.
    rdy_fixed = 0;
    log_q.delete();
    for (int i = 1; i <= 4; i++) send(8'(i), 4'd0);
    check("t2_level_full", oLevel, 4);
    check("t2_rdy_low", oDcpRdy, 0);
    iDcpVld = 1'b1; iDcpPld = 8'h05; iDcpDst = 4'd0;
    tick(); tick();
    check("t2_held_level", oLevel, 4);
    rdy_fixed = 1;
    tick();
    rdy_fixed = 0;
    check("t2_rdy_back", oDcpRdy, 1);
    check("t2_level_after_pop", oLevel, 3);
    tick();
    iDcpVld = 1'b0;
    check("t2_level_refill", oLevel, 4);
    drain();
    check("t2_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check("t2_order", logv(i), 8'(i + 1));

    // Misroute: consumed, counted, sticky.
    rdy_fixed = 1;
    send(8'h00, 4'd2);
    check("t3_errcnt", oErrCnt, 1);
    check("t3_dsterr", oDstErr, 1);
    check("t3_level", oLevel, 0);
    for (int i = 0; i < 20; i++) send(8'(((i % 4) << 4) | (i % 16)), 4'd0);
    tick(); tick();
    check("t3_dsterr_sticky", oDstErr, 1);
    check("t3_errcnt_hold", oErrCnt, 1);

    // Sustained traffic from source 1 with toggling ready.
    do_reset();
    log_q.delete();
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) send(8'h10 | 8'(i), 4'd0);
    drain();
    check("t4_count", log_q.size(), 16);
    for (int i = 0; i < 16; i++) check("t4_order", logv(i), 8'h10 | 8'(i));
    check("t4_src1", oSrcCnt[15:8], 16);

    // Saturation on the narrow-counter instance.
    do_reset();
    rdy_fixed = 1;
    for (int i = 0; i < 20; i++) send(8'h30 | 8'(i % 16), 4'd0);
    tick(); tick();
    check("t5_src3_wide", oSrcCnt[31:24], 20);
    check("t5_src3_sat", s_oSrcCnt[15:12], 15);
    check("t5_src0_sat", s_oSrcCnt[3:0], 0);

    // Reset with three beats buffered.
    do_reset();
    rdy_fixed = 0;
    send(8'h0A, 4'd0); send(8'h1B, 4'd0); send(8'h2C, 4'd0);
    check("t6_level3", oLevel, 3);
    iRst = 1'b1;
    #1;
    check("t6_async_vld", oVld, 0);
    check("t6_async_level", oLevel, 0);
    check("t6_async_cnt", oSrcCnt, 0);
    check("t6_async_rdy", oDcpRdy, 0);
    tick();
    iRst = 1'b0;
    tick();
    rdy_fixed = 1;
    log_q.delete();
    send(8'h25, 4'd0);
    tick(); tick();
    check("t6_first_after_rst", logv(0), 8'h25);
    check("t6_count", log_q.size(), 1);

    // Randomized traffic against the model.
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      else send(8'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcp_egress_port.md
Name: dcp_egress_port

Overview:
- Egress end of the Decoupled switch fabric; one instance sits on each `oDcpOut[k]` of the NxN crossbar.
- Accepts crossbar beats, checks that each beat was routed to this port, and buffers good beats in a FIFO.
- Re-presents buffered beats to the downstream MAC/consumer on a Decoupled interface.
- Keeps per-source receive counters and sticky misroute status for debug and verification.

Parameters:
- DW, 8, payload width (bits).
- AW, 4, destination field width (bits).
- N, 4, number of crossbar sources; power of 2; SW = $clog2(N).
- PORT_ID, 0, this port's destination address (AW bits).
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- CW, 8, per-source counter width (bits).

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  asynchronous active-high reset.
- iDcpVld  in  1  crossbar beat valid.
- oDcpRdy  out  1  ready toward crossbar.
- iDcpPld  in  DW  crossbar payload; source ID in `iDcpPld[AW +: SW]`.
- iDcpDst  in  AW  destination tag carried with the beat.
- oVld  out  1  downstream valid.
- iRdy  in  1  downstream ready.
- oPld  out  DW  downstream payload.
- oSrc  out  SW  source ID of the beat at the FIFO head.
- oLevel  out  $clog2(DEPTH)+1  FIFO occupancy.
- oSrcCnt  out  N*CW  packed per-source good-beat counters; source s occupies `[s*CW +: CW]`.
- oErrCnt  out  CW  misrouted-beat counter.
- oDstErr  out  1  sticky misroute flag.

Behaviour:
- Reset (async assert, sync-safe deassert on iClk): FIFO empty, read/write pointers 0, oLevel=0, oVld=0, oDcpRdy=0 while iRst=1, oPld=0, oSrc=0, all counters 0, oDstErr=0.
- Reset mid-operation: buffered beats are discarded; no output glitches to oVld=1 during reset.
- Ingress handshake:
  - oDcpRdy = !full, derived from registered level; no combinational path from iRdy.
  - A beat is accepted when iDcpVld && oDcpRdy.
  - The upstream may hold iDcpVld with a stable beat indefinitely; the block never drops a held beat.
- Route check on each accepted beat:
  - iDcpDst == PORT_ID: good beat. Written to FIFO as {src, Pld}; the counter for that source increments.
  - iDcpDst != PORT_ID: beat consumed but not written; oErrCnt increments; oDstErr set and held until reset.
- Counters saturate at 2^CW-1 and do not wrap.
- Egress handshake:
  - oVld = !empty.
  - oPld and oSrc reflect the FIFO head and are stable while oVld && !iRdy.
  - A pop occurs when oVld && iRdy.
- Latency: a good beat accepted at edge t is visible on oVld/oPld after edge t (next cycle); minimum one cycle; no bypass path.
- Throughput: one push and one pop per cycle sustained.
  - Simultaneous push and pop leaves the level unchanged.
  - Push is impossible when full (oDcpRdy=0).
  - Pop is impossible when empty (oVld=0).
  - Full with pop in the same cycle: oDcpRdy remains 0 that cycle and rises the next cycle. No combinational ready-through.
- Misrouted beat while full: not accepted, because oDcpRdy=0 gates acceptance regardless of Dst.
- Pointers wrap modulo DEPTH. Level ranges 0..DEPTH; full means level == DEPTH.

Test Plan:
- Reset, then PORT_ID=0 with 4 beats Pld=0x00,0x10,0x20,0x30 (Dst=0), iRdy=1 → oPld sequence 0x00,0x10,0x20,0x30, each one cycle after acceptance; oSrcCnt = 1,1,1,1; oErrCnt=0.
- iRdy=0, push 5 beats with DEPTH=4 → oDcpRdy drops after the 4th accept; oLevel=4; 5th beat held. Then iRdy=1 for 1 cycle → oDcpRdy=1 the next cycle, 5th beat accepted; output order preserved.
- Misroute: beat Dst=2 at PORT_ID=0 → accepted (oDcpRdy=1), FIFO unchanged, oErrCnt=1, oDstErr=1 and sticky through 20 further good beats.
- Sustained traffic: iDcpVld=1 constantly, Pld={src=1,Dst=0}, iRdy toggling every 2 cycles → no loss and no duplication; 16 beats out, oSrcCnt[1]=16.
- Saturation: CW=4, 20 good beats from source 3 → oSrcCnt[3]=15.
- Assert iRst with oLevel=3 → immediately oVld=0, oLevel=0, counters 0. After deassert, the first new beat emerges correctly.
